processor_v2: RTL and testbench

Parametrised successor of the multicycle 16-bit processor. It executes one instruction per `run` request over a register file, an accumulator `A`, a result register `R` and an ALU. It adds several things the first generation lacks: a latched instruction register, a `run`/`done` handshake, condition flags, more ALU operations, an immediate-add and illegal-opcode detection. It is the datapath-plus-control core of the design; an external sequencer or testbench feeds instructions on `iin`.

---
 rtl/processor_v2.sv | 177 +++++++++++++++++
 tb/tb_processor_v2.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_v2.sv
// processor_v2: multicycle core with IR, run/done handshake, ALU flags.
// Ports: clock, resetn, run, iin in; bus, busy, done, err, flag_z/n/c out.
module processor_v2 #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] iin,
    output logic [DATA_W-1:0] bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c
);

    localparam int RB    = $clog2(NREG);
    localparam int IMM_W = DATA_W - 4 - 2 * RB;
    localparam int SW    = $clog2(DATA_W);

    if (IMM_W < 4) begin : g_bad_imm
        $error("processor_v2: immediate field narrower than 4 bits");
    end
    if (NREG < 2 || NREG > 16 || (1 << RB) != NREG) begin : g_bad_nreg
        $error("processor_v2: NREG must be a power of 2 in 2..16");
    end

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] r_reg;
    logic [DATA_W-1:0] regs [NREG];

    logic [3:0]        op;
    logic [RB-1:0]     rx;
    logic [RB-1:0]     ry;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_ext;

    assign op      = ir[DATA_W-1 -: 4];
    assign rx      = ir[DATA_W-5 -: RB];
    assign ry      = ir[DATA_W-5-RB -: RB];
    assign imm     = ir[IMM_W-1:0];
    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    logic cls_move, cls_nop, cls_ill, cls_alu;

    assign cls_move = (op == 4'd0) || (op == 4'd1);
    assign cls_nop  = (op == 4'd11);
    assign cls_ill  = (op >= 4'd12);
    assign cls_alu  = (op >= 4'd2) && (op <= 4'd10);

    logic ir_ld, a_ld, r_ld, rx_wr;

    // Control: bus source selection, load enables and handshake outputs.
    always_comb begin
        state_nxt = state;
        bus       = '0;
        done      = 1'b0;
        err       = 1'b0;
        ir_ld     = 1'b0;
        a_ld      = 1'b0;
        r_ld      = 1'b0;
        rx_wr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) begin
                    ir_ld     = 1'b1;
                    state_nxt = T1;
                end
            end
            T1: begin
                unique case (1'b1)
                    cls_move: begin
                        bus       = (op == 4'd0) ? regs[ry] : imm_ext;
                        rx_wr     = 1'b1;
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                    cls_nop: begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                    cls_ill: begin
                        done      = 1'b1;
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end
                    cls_alu: begin
                        bus       = regs[rx];
                        a_ld      = 1'b1;
                        state_nxt = T2;
                    end
                endcase
            end
            T2: begin
                bus       = (op == 4'd10) ? imm_ext : regs[ry];
                r_ld      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                bus       = r_reg;
                rx_wr     = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum;

    assign sum = {1'b0, a_reg} + {1'b0, bus};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (op)
            4'd2, 4'd10: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            4'd3: begin
                alu_res = a_reg - bus;
                alu_c   = (a_reg < bus);
            end
            4'd4: alu_res = a_reg & bus;
            4'd5: alu_res = a_reg | bus;
            4'd6: alu_res = a_reg ^ bus;
            4'd7: alu_res = {{(DATA_W-1){1'b0}},
                             ($signed(a_reg) < $signed(bus))};
            // Shift amount is truncated, so it never reaches DATA_W.
            4'd8: alu_res = a_reg << bus[SW-1:0];
            4'd9: alu_res = a_reg >> bus[SW-1:0];
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            ir     <= '0;
            a_reg  <= '0;
            r_reg  <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (ir_ld) ir <= iin;
            if (a_ld) a_reg <= bus;
            if (r_ld) begin
                r_reg  <= alu_res;
                flag_z <= (alu_res == '0);
                flag_n <= alu_res[DATA_W-1];
                flag_c <= alu_c;
            end
            if (rx_wr) regs[rx] <= bus;
        end
    end

endmodule

// File: tb/tb_processor_v2.sv
// tb_processor_v2: directed self-checking bench for processor_v2.
// Drives on the falling edge, samples on the falling edge.
module tb_processor_v2;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [15:0] iin;
    logic [15:0] bus;
    logic        busy;
    logic        done;
    logic        err;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;

    int total = 0;
    int bad   = 0;

    processor_v2 #(.DATA_W(16), .NREG(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .run    (run),
        .iin    (iin),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] enc(input int op, input int rx,
                                        input int ry, input int imm);
        logic [3:0] o;
        logic [2:0] x;
        logic [2:0] y;
        logic [5:0] m;
        o = op[3:0];
        x = rx[2:0];
        y = ry[2:0];
        m = imm[5:0];
        return {o, x, y, m};
    endfunction

    // Issue one instruction; report bus/err in the done cycle and the
    // number of cycles after acceptance until done (-1 on timeout).
    task automatic exec(input logic [15:0] instr, output logic [15:0] b,
                        output logic e, output int cyc);
        @(negedge clock);
        iin = instr;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        iin = 16'($urandom);
        cyc = 1;
        while (!done && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        b = bus;
        e = err;
        if (!done) cyc = -1;
    endtask

    task automatic read_reg(input int r, output logic [15:0] v);
        logic e;
        int   c;
        exec(enc(0, r, r, 0), v, e, c);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        run    = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        resetn = 1'b0;
        run    = 1'b0;
        iin    = 16'h0;
        repeat (2) @(negedge clock);
        total++;
        if ({busy, done, err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=000", {busy, done, err});
        end
        total++;
        if (bus !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h want=0000", bus);
        end
        total++;
        if ({flag_z, flag_n, flag_c} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000",
                     {flag_z, flag_n, flag_c});
        end
        resetn = 1'b1;
        read_reg(5, v);
        total++;
        if (v !== 16'h0) begin
            bad++;
            $display("FAIL reset_r5 got=%h want=0000", v);
        end
    endtask

    task automatic test_mvi();
        logic [15:0] b;
        logic        e;
        int          c;
        exec(enc(1, 1, 0, 5), b, e, c);
        total++;
        if (b !== 16'h0005 || c !== 1 || e !== 1'b0) begin
            bad++;
            $display("FAIL mvi_r1 bus=%h cyc=%0d err=%b want 0005/1/0",
                     b, c, e);
        end
        exec(enc(1, 2, 0, 6'b111101), b, e, c);
        total++;
        if (b !== 16'hFFFD || c !== 1) begin
            bad++;
            $display("FAIL mvi_r2 bus=%h cyc=%0d want FFFD/1", b, c);
        end
        read_reg(1, b);
        total++;
        if (b !== 16'h0005) begin
            bad++;
            $display("FAIL rd_r1 got=%h want=0005", b);
        end
        read_reg(2, b);
        total++;
        if (b !== 16'hFFFD) begin
            bad++;
            $display("FAIL rd_r2 got=%h want=FFFD", b);
        end
    endtask

    task automatic test_add();
        logic [15:0] b;
        logic        e;
        int          c;
        exec(enc(2, 1, 2, 0), b, e, c);
        total++;
        if (c !== 3 || b !== 16'h0002 || e !== 1'b0) begin
            bad++;
            $display("FAIL add cyc=%0d bus=%h err=%b want 3/0002/0",
                     c, b, e);
        end
        total++;
        if ({flag_z, flag_n, flag_c} !== 3'b001) begin
            bad++;
            $display("FAIL add_flags got=%b want=001",
                     {flag_z, flag_n, flag_c});
        end
        read_reg(1, b);
        total++;
        if (b !== 16'h0002) begin
            bad++;
            $display("FAIL add_r1 got=%h want=0002", b);
        end
    endtask

    task automatic test_sub_slt();
        logic [15:0] b;
        logic        e;
        int          c;
        exec(enc(1, 3, 0, 7), b, e, c);
        exec(enc(3, 3, 3, 0), b, e, c);
        total++;
        if (b !== 16'h0 || {flag_z, flag_n, flag_c} !== 3'b100) begin
            bad++;
            $display("FAIL sub_self bus=%h flags=%b want 0000/100",
                     b, {flag_z, flag_n, flag_c});
        end
        exec(enc(1, 1, 0, 1), b, e, c);
        exec(enc(1, 2, 0, 6'h3F), b, e, c);
        exec(enc(7, 1, 2, 0), b, e, c);
        read_reg(1, b);
        total++;
        if (b !== 16'h0) begin
            bad++;
            $display("FAIL slt_false got=%h want=0000", b);
        end
        exec(enc(1, 1, 0, 6'h3E), b, e, c);
        exec(enc(1, 2, 0, 1), b, e, c);
        exec(enc(7, 1, 2, 0), b, e, c);
        total++;
        if (b !== 16'h0001) begin
            bad++;
            $display("FAIL slt_true got=%h want=0001", b);
        end
    endtask

    task automatic test_logic_shift();
        logic [15:0] b;
        logic        e;
        int          c;
        exec(enc(1, 4, 0, 12), b, e, c);
        exec(enc(1, 5, 0, 10), b, e, c);
        exec(enc(0, 6, 4, 0), b, e, c);
        exec(enc(4, 6, 5, 0), b, e, c);
        total++;
        if (b !== 16'h0008) begin
            bad++;
            $display("FAIL and got=%h want=0008", b);
        end
        exec(enc(0, 6, 4, 0), b, e, c);
        exec(enc(5, 6, 5, 0), b, e, c);
        total++;
        if (b !== 16'h000E) begin
            bad++;
            $display("FAIL or got=%h want=000E", b);
        end
        exec(enc(0, 6, 4, 0), b, e, c);
        exec(enc(6, 6, 5, 0), b, e, c);
        total++;
        if (b !== 16'h0006) begin
            bad++;
            $display("FAIL xor got=%h want=0006", b);
        end
        exec(enc(0, 6, 4, 0), b, e, c);
        exec(enc(8, 6, 5, 0), b, e, c);
        total++;
        if (b !== 16'h3000 || {flag_z, flag_n, flag_c} !== 3'b000) begin
            bad++;
            $display("FAIL shl bus=%h flags=%b want 3000/000",
                     b, {flag_z, flag_n, flag_c});
        end
        exec(enc(1, 7, 0, 6'h30), b, e, c);
        exec(enc(1, 0, 0, 4), b, e, c);
        exec(enc(9, 7, 0, 0), b, e, c);
        total++;
        if (b !== 16'h0FFF) begin
            bad++;
            $display("FAIL shr got=%h want=0FFF", b);
        end
        exec(enc(1, 0, 0, 17), b, e, c);
        exec(enc(8, 5, 0, 0), b, e, c);
        total++;
        if (b !== 16'h0014) begin
            bad++;
            $display("FAIL shl_trunc got=%h want=0014", b);
        end
        exec(enc(1, 6, 0, 3), b, e, c);
        exec(enc(1, 5, 0, 10), b, e, c);
        exec(enc(3, 6, 5, 0), b, e, c);
        total++;
        if (b !== 16'hFFF9 || {flag_z, flag_n, flag_c} !== 3'b011) begin
            bad++;
            $display("FAIL sub_borrow bus=%h flags=%b want FFF9/011",
                     b, {flag_z, flag_n, flag_c});
        end
        exec(enc(10, 6, 0, 6'h39), b, e, c);
        total++;
        if (b !== 16'hFFF2 || c !== 3 || flag_c !== 1'b1) begin
            bad++;
            $display("FAIL addi bus=%h cyc=%0d c=%b want FFF2/3/1",
                     b, c, flag_c);
        end
        exec(enc(1, 1, 0, 6'h3F), b, e, c);
        exec(enc(1, 2, 0, 1), b, e, c);
        total++;
        if ({flag_z, flag_n, flag_c} !== 3'b011) begin
            bad++;
            $display("FAIL mvi_keeps_flags got=%b want=011",
                     {flag_z, flag_n, flag_c});
        end
        exec(enc(2, 1, 2, 0), b, e, c);
        total++;
        if (b !== 16'h0 || {flag_z, flag_n, flag_c} !== 3'b101) begin
            bad++;
            $display("FAIL add_wrap bus=%h flags=%b want 0000/101",
                     b, {flag_z, flag_n, flag_c});
        end
    endtask

    task automatic test_illegal();
        logic [15:0] b;
        logic        e;
        int          c;
        exec(16'hF000, b, e, c);
        total++;
        if (c !== 1 || e !== 1'b1) begin
            bad++;
            $display("FAIL illegal cyc=%0d err=%b want 1/1", c, e);
        end
        total++;
        if ({flag_z, flag_n, flag_c} !== 3'b101) begin
            bad++;
            $display("FAIL illegal_flags got=%b want=101",
                     {flag_z, flag_n, flag_c});
        end
        read_reg(0, b);
        total++;
        if (b !== 16'h0011) begin
            bad++;
            $display("FAIL illegal_r0 got=%h want=0011", b);
        end
        exec(enc(11, 0, 0, 0), b, e, c);
        total++;
        if (c !== 1 || e !== 1'b0) begin
            bad++;
            $display("FAIL nop cyc=%0d err=%b want 1/0", c, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        logic [15:0] b;
        logic        prev_busy;
        int          acc;
        int          dones;
        int          cyc;
        prog[0] = enc(1, 1, 0, 9);
        prog[1] = enc(2, 1, 1, 0);
        prog[2] = enc(0, 2, 1, 0);
        acc       = 0;
        dones     = 0;
        cyc       = 0;
        prev_busy = 1'b0;
        @(negedge clock);
        iin = prog[0];
        run = 1'b1;
        while (!(acc == 3 && !busy) && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (busy && !prev_busy) acc++;
            if (done) dones++;
            prev_busy = busy;
            if (!busy) begin
                if (acc < 3) begin
                    iin = prog[acc];
                    run = 1'b1;
                end else begin
                    run = 1'b0;
                end
            end else begin
                iin = 16'($urandom);
                run = 1'b1;
            end
        end
        run = 1'b0;
        total++;
        if (acc !== 3 || dones !== 3) begin
            bad++;
            $display("FAIL b2b_counts acc=%0d done=%0d want 3/3",
                     acc, dones);
        end
        total++;
        if (cyc !== 8) begin
            bad++;
            $display("FAIL b2b_cycles got=%0d want=8", cyc);
        end
        read_reg(2, b);
        total++;
        if (b !== 16'h0012) begin
            bad++;
            $display("FAIL b2b_r2 got=%h want=0012", b);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] b;
        logic        e;
        int          c;
        logic        saw_done;
        do_reset();
        exec(enc(1, 2, 0, 6'h3F), b, e, c);
        exec(enc(2, 2, 2, 0), b, e, c);
        @(negedge clock);
        iin = enc(2, 1, 2, 0);
        run = 1'b1;
        @(negedge clock);
        run      = 1'b0;
        saw_done = done;
        @(negedge clock);
        saw_done = saw_done | done;
        resetn   = 1'b0;
        @(negedge clock);
        saw_done = saw_done | done;
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_done got=%b want=0", saw_done);
        end
        total++;
        if ({busy, done, err, flag_z, flag_n, flag_c} !== 6'b0 ||
            bus !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid_outs ctl=%b bus=%h want 000000/0000",
                     {busy, done, err, flag_z, flag_n, flag_c}, bus);
        end
        resetn = 1'b1;
        read_reg(1, b);
        total++;
        if (b !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid_r1 got=%h want=0000", b);
        end
        read_reg(2, b);
        total++;
        if (b !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid_r2 got=%h want=0000", b);
        end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_sub_slt();
        test_logic_shift();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
